// File: rtl/vga_sync_gen.sv
// VGA horizontal/vertical timing generator with blanked RGB output.
// Counters walk active/front-porch/sync/back-porch; all outputs are registered one cycle behind them.
module vga_sync_gen #(
  parameter int H_ACTIVE      = 640,
  parameter int H_FP          = 16,
  parameter int H_SYNC        = 96,
  parameter int H_BP          = 48,
  parameter int V_ACTIVE      = 480,
  parameter int V_FP          = 10,
  parameter int V_SYNC        = 2,
  parameter int V_BP          = 33,
  parameter bit SYNC_POL      = 1'b0,
  parameter int DATA_WIDTH    = 12,
  parameter int COUNTER_WIDTH = 10
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     En,
  input  logic [DATA_WIDTH-1:0]    Data_VGA,
  output logic                     HSync,
  output logic                     VSync,
  output logic                     Video_Active,
  output logic [DATA_WIDTH-1:0]    RGB_Out,
  output logic                     Frame_Start,
  output logic [COUNTER_WIDTH-1:0] H_Count,
  output logic [COUNTER_WIDTH-1:0] V_Count
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [COUNTER_WIDTH-1:0] CNT_ZERO  = {COUNTER_WIDTH{1'b0}};
  localparam logic [COUNTER_WIDTH-1:0] CNT_ONE   = {{(COUNTER_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [COUNTER_WIDTH-1:0] H_LAST    = COUNTER_WIDTH'(H_TOTAL - 1);
  localparam logic [COUNTER_WIDTH-1:0] V_LAST    = COUNTER_WIDTH'(V_TOTAL - 1);
  localparam logic [COUNTER_WIDTH-1:0] H_ACT_END = COUNTER_WIDTH'(H_ACTIVE);
  localparam logic [COUNTER_WIDTH-1:0] V_ACT_END = COUNTER_WIDTH'(V_ACTIVE);
  localparam logic [COUNTER_WIDTH-1:0] HS_FIRST  = COUNTER_WIDTH'(H_ACTIVE + H_FP);
  localparam logic [COUNTER_WIDTH-1:0] HS_LAST   = COUNTER_WIDTH'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [COUNTER_WIDTH-1:0] VS_FIRST  = COUNTER_WIDTH'(V_ACTIVE + V_FP);
  localparam logic [COUNTER_WIDTH-1:0] VS_LAST   = COUNTER_WIDTH'(V_ACTIVE + V_FP + V_SYNC - 1);

  localparam logic SYNC_ON  = SYNC_POL;
  localparam logic SYNC_OFF = ~SYNC_POL;
  localparam logic [DATA_WIDTH-1:0] RGB_BLANK = {DATA_WIDTH{1'b0}};

  logic [COUNTER_WIDTH-1:0] h_cnt_r;
  logic [COUNTER_WIDTH-1:0] v_cnt_r;
  logic [COUNTER_WIDTH-1:0] h_nxt_s;
  logic [COUNTER_WIDTH-1:0] v_nxt_s;

  logic                  hs_on_s;
  logic                  vs_on_s;
  logic                  act_s;
  logic                  first_px_s;

  logic                  hsync_r;
  logic                  vsync_r;
  logic                  video_active_r;
  logic [DATA_WIDTH-1:0] rgb_r;
  logic                  frame_start_r;

  // Next counter values; >= on the wrap compare so a corrupted counter recovers within one line/frame.
  always_comb begin
    h_nxt_s = h_cnt_r;
    v_nxt_s = v_cnt_r;
    if (!En) begin
      h_nxt_s = CNT_ZERO;
      v_nxt_s = CNT_ZERO;
    end else if (h_cnt_r >= H_LAST) begin
      h_nxt_s = CNT_ZERO;
      if (v_cnt_r >= V_LAST) begin
        v_nxt_s = CNT_ZERO;
      end else begin
        v_nxt_s = v_cnt_r + CNT_ONE;
      end
    end else begin
      h_nxt_s = h_cnt_r + CNT_ONE;
      v_nxt_s = v_cnt_r;
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt_r <= CNT_ZERO;
      v_cnt_r <= CNT_ZERO;
    end else begin
      h_cnt_r <= h_nxt_s;
      v_cnt_r <= v_nxt_s;
    end
  end

  // Segment decode on the current counter values.
  always_comb begin
    hs_on_s    = (h_cnt_r >= HS_FIRST) && (h_cnt_r <= HS_LAST);
    vs_on_s    = (v_cnt_r >= VS_FIRST) && (v_cnt_r <= VS_LAST);
    act_s      = (h_cnt_r < H_ACT_END) && (v_cnt_r < V_ACT_END);
    first_px_s = (h_cnt_r == CNT_ZERO) && (v_cnt_r == CNT_ZERO);
  end

  // Output registers; a low En forces the idle/blanked state so no sync pulse is stretched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hsync_r        <= SYNC_OFF;
      vsync_r        <= SYNC_OFF;
      video_active_r <= 1'b0;
      rgb_r          <= RGB_BLANK;
      frame_start_r  <= 1'b0;
    end else if (!En) begin
      hsync_r        <= SYNC_OFF;
      vsync_r        <= SYNC_OFF;
      video_active_r <= 1'b0;
      rgb_r          <= RGB_BLANK;
      frame_start_r  <= 1'b0;
    end else begin
      hsync_r        <= hs_on_s ? SYNC_ON : SYNC_OFF;
      vsync_r        <= vs_on_s ? SYNC_ON : SYNC_OFF;
      video_active_r <= act_s;
      rgb_r          <= act_s ? Data_VGA : RGB_BLANK;
      frame_start_r  <= first_px_s;
    end
  end

  assign HSync        = hsync_r;
  assign VSync        = vsync_r;
  assign Video_Active = video_active_r;
  assign RGB_Out      = rgb_r;
  assign Frame_Start  = frame_start_r;
  assign H_Count      = h_cnt_r;
  assign V_Count      = v_cnt_r;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Randomized bench for vga_sync_gen (reduced timing) against an arithmetic pixel-position model.
module tb_vga_sync_gen;

  localparam int HA = 16, HF = 4, HS = 6, HB = 5;
  localparam int VA = 10, VF = 2, VS = 2, VB = 3;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;
  localparam logic POL = 1'b0;
  localparam int DW = 12;
  localparam int CW = 6;

  logic          clk;
  logic          rst_n;
  logic          en;
  logic [DW-1:0] data;
  logic          hsync, vsync, vact, fstart;
  logic [DW-1:0] rgb;
  logic [CW-1:0] hcnt, vcnt;

  int n_tests;
  int n_fail;

  // Model: pixel index within the frame of the counters, plus expected registered outputs.
  int            pos;
  logic          e_hs, e_vs, e_va, e_fs;
  logic [DW-1:0] e_rgb;
  int            e_h, e_v;

  vga_sync_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_POL(POL), .DATA_WIDTH(DW), .COUNTER_WIDTH(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .En(en), .Data_VGA(data),
    .HSync(hsync), .VSync(vsync), .Video_Active(vact), .RGB_Out(rgb),
    .Frame_Start(fstart), .H_Count(hcnt), .V_Count(vcnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_idle();
    pos   = 0;
    e_hs  = ~POL;
    e_vs  = ~POL;
    e_va  = 1'b0;
    e_rgb = '0;
    e_fs  = 1'b0;
    e_h   = 0;
    e_v   = 0;
  endtask

  task automatic model_clock(input logic cur_en, input logic [DW-1:0] cur_data);
    int h, v;
    if (!cur_en) begin
      model_idle();
    end else begin
      h     = pos % HT;
      v     = pos / HT;
      e_hs  = (h >= HA + HF && h < HA + HF + HS) ? POL : ~POL;
      e_vs  = (v >= VA + VF && v < VA + VF + VS) ? POL : ~POL;
      e_va  = (h < HA) && (v < VA);
      e_rgb = e_va ? cur_data : '0;
      e_fs  = (pos == 0);
      pos   = (pos + 1) % FRAME;
      e_h   = pos % HT;
      e_v   = pos / HT;
    end
  endtask

  task automatic compare_all();
    check("hsync",  32'(hsync),  32'(e_hs));
    check("vsync",  32'(vsync),  32'(e_vs));
    check("vact",   32'(vact),   32'(e_va));
    check("rgb",    32'(rgb),    32'(e_rgb));
    check("fstart", 32'(fstart), 32'(e_fs));
    check("hcnt",   32'(hcnt),   32'(e_h));
    check("vcnt",   32'(vcnt),   32'(e_v));
  endtask

  // One clock: update the model at the edge, compare on the falling edge, leave inputs to the caller.
  task automatic step();
    @(posedge clk);
    if (!rst_n) model_idle();
    else model_clock(en, data);
    @(negedge clk);
    compare_all();
  endtask

  task automatic run_random(input int cycles, input bit toggle_en);
    for (int i = 0; i < cycles; i++) begin
      step();
      data = DW'($urandom_range(0, 4095));
      if (toggle_en) begin
        if (en) en = ($urandom_range(0, 299) != 0);
        else    en = ($urandom_range(0, 2) == 0);
      end
    end
  endtask

  initial begin
    bit found;
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    en      = 1'b1;
    data    = 12'hABC;
    model_idle();

    // Reset held with En high: outputs stay at reset values.
    repeat (3) step();
    rst_n = 1'b1;

    // Constant pixel over a full frame, then randomized data with occasional En drops.
    run_random(FRAME + 5, 1'b0);
    en = 1'b1;
    run_random(4 * FRAME, 1'b1);
    en = 1'b1;
    run_random(FRAME, 1'b0);

    // Drop En in the middle of the horizontal sync pulse.
    found = 1'b0;
    for (int i = 0; i < 2 * FRAME && !found; i++) begin
      step();
      data = DW'($urandom_range(0, 4095));
      if (e_h == HA + HF + 2) found = 1'b1;
    end
    check("wait_hsync", 32'(found), 32'd1);
    en = 1'b0;
    step();
    en = 1'b1;
    run_random(2 * FRAME, 1'b0);

    // Asynchronous reset in the middle of a visible line.
    found = 1'b0;
    for (int i = 0; i < 2 * FRAME && !found; i++) begin
      step();
      data = DW'($urandom_range(0, 4095));
      if (e_v == VA / 2 && e_va) found = 1'b1;
    end
    check("wait_mid", 32'(found), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    model_idle();
    compare_all();
    repeat (2) step();
    rst_n = 1'b1;
    run_random(2 * FRAME, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_sync_gen.md
Name: vga_sync_gen

Overview:
- Generates VGA horizontal/vertical timing for the display path downstream of the configuration manager.
- Its HSync/VSync outputs drive the configuration manager's horizontal and vertical pixel counters.
- Samples the pixel word the configuration manager returns (Data_VGA) and drives the blanked RGB bus to the DAC/pins.
- Default timing is 640x480 @ 60 Hz with a 25 MHz pixel clock.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, horizontal sync width (clocks)
- H_BP, 48, horizontal back porch (clocks)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- SYNC_POL, 0, asserted sync level (0 = active-low)
- DATA_WIDTH, 12, pixel word width (4:4:4 RGB)
- COUNTER_WIDTH, 10, width of H/V counters; must hold H_TOTAL-1 and V_TOTAL-1

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  asynchronous active-low reset
- En  in  1  timing enable; low holds generator idle
- Data_VGA  in  DATA_WIDTH  pixel from configuration manager
- HSync  out  1  horizontal sync
- VSync  out  1  vertical sync
- Video_Active  out  1  high while the output pixel is in the visible region
- RGB_Out  out  DATA_WIDTH  blanked pixel output
- Frame_Start  out  1  one-cycle pulse at the first pixel of each frame
- H_Count  out  COUNTER_WIDTH  current horizontal counter (debug)
- V_Count  out  COUNTER_WIDTH  current vertical counter (debug)

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values:
  - H_Count = 0, V_Count = 0.
  - HSync = VSync = ~SYNC_POL (deasserted).
  - Video_Active = 0, RGB_Out = 0, Frame_Start = 0.
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800). V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- Counters, when En = 1:
  - H_Count increments each clock.
  - At H_TOTAL-1, H_Count wraps to 0 and V_Count increments.
  - V_Count wraps to 0 when H_Count = H_TOTAL-1 and V_Count = V_TOTAL-1 together.
  - Counter arithmetic is unsigned at COUNTER_WIDTH; counters never exceed TOTAL-1.
- Segment order per line: active, front porch, sync, back porch. The same order applies per frame, counted in lines.
- Decode, evaluated on the current counter values:
  - hs_on = H_Count in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], i.e. [656, 751].
  - vs_on = V_Count in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1], i.e. [490, 491].
  - act = (H_Count < H_ACTIVE) and (V_Count < V_ACTIVE).
- Outputs are registered, with 1-cycle latency from the counters:
  - HSync <= hs_on ? SYNC_POL : ~SYNC_POL. VSync is formed the same way from vs_on.
  - Video_Active <= act.
  - RGB_Out <= act ? Data_VGA : 0. Data_VGA is sampled in the same cycle as the counter value.
  - Frame_Start <= (H_Count == 0 and V_Count == 0 and En).
- All five registered outputs are cycle-aligned to each other.
- VSync changes only in the output cycle corresponding to H_Count = 0.
- En low (at any point, including mid-line or mid-frame):
  - On the next edge, counters clear to 0.
  - HSync/VSync are deasserted; Video_Active, RGB_Out and Frame_Start are 0.
  - No partial sync pulse is extended.
- En rising: the first enabled cycle is H = 0, V = 0. Frame_Start pulses one cycle later.
- Reset asserted mid-operation: all outputs return to reset values immediately (asynchronous). Timing restarts at 0,0 after release.
- No handshake on Data_VGA: the upstream block must present the pixel in the same cycle. Its counters are driven by this block's syncs.

Test Plan:
- Reset with En = 1, then release → all outputs at reset values during reset. First Frame_Start 1 cycle after release. HSync deasserted (1) until output cycle 657.
- Line timing → HSync low for exactly 96 consecutive cycles, starting at output cycle 657 after H = 0. HSync period is 800 cycles.
- Frame timing → VSync low for exactly 2 lines (1600 cycles), starting at line 490 aligned with the H = 0 output cycle. Frame_Start period is 420000 cycles.
- Data_VGA = 12'hABC constant → RGB_Out = 12'hABC for 640 cycles per line on lines 0-479. RGB_Out = 0 in all porches, sync and lines 480-524. Video_Active matches.
- Drop En at H = 700 (inside HSync) → HSync = 1 next cycle and counters = 0. After En returns high, the first Frame_Start follows 1 cycle later.
- Assert rst_n low at V = 300 asynchronously → outputs go to reset values without waiting for clk. Timing restarts cleanly from 0,0.
